// File: rtl/sensor_conditioner.sv
// Sensor front end: synchronises and debounces the four binary sensors
// and turns the ADC temperature stream into a sliding-window average.

module sensor_conditioner_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_out <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_out;
endmodule

module sensor_conditioner_avg #(
    parameter int         LOG2 = 2,
    parameter logic [7:0] INIT = 8'd60
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic [7:0] o_st,
    output logic       o_valid
);
    localparam int N  = 1 << LOG2;
    localparam int SW = 8 + LOG2;
    localparam int PW = (LOG2 > 0) ? LOG2 : 1;
    localparam int FW = $clog2(N + 1);

    logic [7:0]    r_buf [N];
    logic [PW-1:0] r_wr_ptr;
    logic [FW-1:0] r_fill;
    logic [SW-1:0] r_sum;
    logic [7:0]    r_st;
    logic          r_valid;

    logic [7:0]    w_old;
    logic [SW-1:0] w_sum_next;
    logic [FW-1:0] w_fill_next;
    logic [PW-1:0] w_ptr_next;
    logic          w_full_next;
    logic [7:0]    w_avg;

    // The oldest sample sits where the next one is written; buffer is
    // zeroed at reset so subtracting it before the window fills is harmless.
    assign w_old       = r_buf[r_wr_ptr];
    assign w_sum_next  = r_sum + SW'(i_data) - SW'(w_old);
    assign w_fill_next = (r_fill == FW'(N)) ? r_fill : r_fill + FW'(1);
    assign w_full_next = (w_fill_next == FW'(N));
    assign w_ptr_next  = (r_wr_ptr == PW'(N - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_avg       = 8'(w_sum_next >> LOG2);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_sum    <= '0;
            r_st     <= INIT;
            r_valid  <= 1'b0;
        end else if (i_valid) begin
            r_buf[r_wr_ptr] <= i_data;
            r_wr_ptr        <= w_ptr_next;
            r_fill          <= w_fill_next;
            r_sum           <= w_sum_next;
            if (w_full_next) begin
                r_st    <= w_avg;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_st    = r_st;
    assign o_valid = r_valid;
endmodule

module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         AVG_LOG2        = 2,
    parameter logic [7:0] ST_INIT         = 8'd60
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [7:0] ST,
    output logic       st_valid
);
    logic [3:0] w_raw;
    logic [3:0] w_level;

    assign w_raw = {raw_fd, raw_rd, raw_w, raw_fa};

    for (genvar g = 0; g < 4; g++) begin : g_dbn
        sensor_conditioner_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_dbn (
            .clk    (clk),
            .i_rst  (Rst),
            .i_raw  (w_raw[g]),
            .o_level(w_level[g])
        );
    end

    assign {SFD, SRD, SW, SFA} = w_level;

    sensor_conditioner_avg #(
        .LOG2(AVG_LOG2),
        .INIT(ST_INIT)
    ) u_avg (
        .clk    (clk),
        .i_rst  (Rst),
        .i_data (adc_data),
        .i_valid(adc_valid),
        .o_st   (ST),
        .o_valid(st_valid)
    );
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: vector table for the averager plus
// hand-built debounce sequences, all checked through an expect queue.

module tb_sensor_conditioner;
    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       raw_fd = 1'b0;
    logic       raw_rd = 1'b0;
    logic       raw_w = 1'b0;
    logic       raw_fa = 1'b0;
    logic [7:0] adc_data = '0;
    logic       adc_valid = 1'b0;
    logic       SFD, SRD, SW, SFA;
    logic [7:0] ST;
    logic       st_valid;

    always #5 clk = ~clk;

    sensor_conditioner dut (
        .clk      (clk),
        .Rst      (Rst),
        .raw_fd   (raw_fd),
        .raw_rd   (raw_rd),
        .raw_w    (raw_w),
        .raw_fa   (raw_fa),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .SFD      (SFD),
        .SRD      (SRD),
        .SW       (SW),
        .SFA      (SFA),
        .ST       (ST),
        .st_valid (st_valid)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic [3:0] raw;
        logic [3:0] dbn;
        logic [7:0] st;
        logic       stv;
        logic       cks;
        logic [9:0] sum;
        string      nm;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string nm, logic rst, logic vld,
                                logic [7:0] d, logic [3:0] raw,
                                logic [3:0] dbn, logic [7:0] st,
                                logic stv, logic cks = 1'b0,
                                logic [9:0] sum = '0);
        vec_t v;
        v.nm  = nm;
        v.rst = rst;
        v.vld = vld;
        v.d   = d;
        v.raw = raw;
        v.dbn = dbn;
        v.st  = st;
        v.stv = stv;
        v.cks = cks;
        v.sum = sum;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        Rst       = v.rst;
        adc_valid = v.vld;
        adc_data  = v.d;
        {raw_fd, raw_rd, raw_w, raw_fa} = v.raw;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, " dbn"}, int'({SFD, SRD, SW, SFA}), int'(e.dbn));
        chk({e.nm, " ST"}, int'(ST), int'(e.st));
        chk({e.nm, " st_valid"}, int'(st_valid), int'(e.stv));
        if (e.cks) begin
            chk({e.nm, " sum"}, int'(dut.u_avg.r_sum), int'(e.sum));
        end
    endtask

    initial begin
        // reset with toggling raws and a sample that must be dropped
        tbl.push_back(mk("rst0", 1, 1, 8'd200, 4'b1010, 0, 60, 0));
        tbl.push_back(mk("rst1", 1, 1, 8'd200, 4'b0101, 0, 60, 0));
        tbl.push_back(mk("s80a", 0, 1, 8'd80, 0, 0, 60, 0));
        tbl.push_back(mk("s80b", 0, 1, 8'd80, 0, 0, 60, 0));
        tbl.push_back(mk("s80c", 0, 1, 8'd80, 0, 0, 60, 0));
        tbl.push_back(mk("s80d", 0, 1, 8'd80, 0, 0, 80, 1));
        tbl.push_back(mk("s40a", 0, 1, 8'd40, 0, 0, 70, 1));
        tbl.push_back(mk("s40b", 0, 1, 8'd40, 0, 0, 60, 1));
        tbl.push_back(mk("idle", 0, 0, 8'd9, 0, 0, 60, 1));
        tbl.push_back(mk("s255a", 0, 1, 8'd255, 0, 0, 103, 1));
        tbl.push_back(mk("s255b", 0, 1, 8'd255, 0, 0, 147, 1));
        tbl.push_back(mk("s255c", 0, 1, 8'd255, 0, 0, 201, 1));
        tbl.push_back(mk("s255d", 0, 1, 8'd255, 0, 0, 255, 1, 1, 10'd1020));
        tbl.push_back(mk("s0a", 0, 1, 8'd0, 0, 0, 191, 1));
        tbl.push_back(mk("s0b", 0, 1, 8'd0, 0, 0, 127, 1));
        tbl.push_back(mk("s0c", 0, 1, 8'd0, 0, 0, 63, 1));
        tbl.push_back(mk("s0d", 0, 1, 8'd0, 0, 0, 0, 1, 1, 10'd0));
        tbl.push_back(mk("rstB", 1, 0, 8'd0, 0, 0, 60, 0));
        tbl.push_back(mk("s90a", 0, 1, 8'd90, 0, 0, 60, 0));
        tbl.push_back(mk("s90b", 0, 1, 8'd90, 0, 0, 60, 0));
        tbl.push_back(mk("rstC", 1, 1, 8'd90, 0, 0, 60, 0));
        tbl.push_back(mk("s20a", 0, 1, 8'd20, 0, 0, 60, 0));
        tbl.push_back(mk("s20b", 0, 1, 8'd20, 0, 0, 60, 0));
        tbl.push_back(mk("s20c", 0, 1, 8'd20, 0, 0, 60, 0));
        tbl.push_back(mk("s20d", 0, 1, 8'd20, 0, 0, 20, 1, 1, 10'd80));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // clean step on raw_fd: first sampling edge is i=1
        for (int i = 1; i <= 7; i++) begin
            apply(mk($sformatf("fd_rise%0d", i), 0, 0, 0, 4'b1000,
                     (i >= 6) ? 4'b1000 : 4'b0000, 20, 1));
        end
        // three-cycle glitch on raw_fa must be swallowed
        for (int i = 1; i <= 3; i++) begin
            apply(mk($sformatf("fa_pulse%0d", i), 0, 0, 0, 4'b1001,
                     4'b1000, 20, 1));
        end
        for (int i = 1; i <= 6; i++) begin
            apply(mk($sformatf("fa_after%0d", i), 0, 0, 0, 4'b1000,
                     4'b1000, 20, 1));
        end
        for (int i = 1; i <= 7; i++) begin
            apply(mk($sformatf("fd_fall%0d", i), 0, 0, 0, 4'b0000,
                     (i >= 6) ? 4'b0000 : 4'b1000, 20, 1));
        end

        // everything at once: four sensors step high while ADC streams
        apply(mk("rstD", 1, 1, 8'd99, 0, 0, 60, 0));
        for (int i = 1; i <= 8; i++) begin
            apply(mk($sformatf("all%0d", i), 0, 1, 8'd100, 4'b1111,
                     (i >= 6) ? 4'b1111 : 4'b0000,
                     (i >= 4) ? 8'd100 : 8'd60, i >= 4,
                     i == 4, 10'd400));
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
